imem_loader: RTL and testbench

Program loader that fills the instruction memory of the single-cycle MIPS core from a byte stream instead of a simulation-time file load. Accepts a framed stream of bytes over a valid/ready handshake, assembles big-endian 32-bit instruction words and issues one write per word to the instruction-memory write port. Holds the CPU (`cpu_hold`) from reset until a frame loads and verifies cleanly.

---
 rtl/imem_loader.sv | 126 ++++++++++++
 tb/tb_imem_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader for the instruction memory (optional checksum: LOADER_CHECKSUM_EN)
module imem_loader #(
    parameter int          ADDR_W     = 8,
    parameter int unsigned BASE_ADDR  = 0,
    parameter logic [7:0]  START_BYTE = 8'hA5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, COUNT, DATA, CHECK, DONE, ERROR} state_t;
`else
    typedef enum logic [2:0] {IDLE, COUNT, DATA, DONE, ERROR} state_t;
`endif

    state_t            state;
    state_t            state_next;
    logic [7:0]        count_q;
    logic [7:0]        word_cnt;
    logic [1:0]        byte_idx;
    logic [23:0]       asm_q;
    logic [ADDR_W-1:0] next_addr;
    logic              accept;
    logic              last_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign byte_ready = !RST;
    assign accept     = byte_valid && byte_ready;
    assign last_word  = (word_cnt == count_q - 8'd1);

    // Status flags are pure functions of the state, so they follow the deciding byte by one cycle
    assign done     = (state == DONE);
    assign err      = (state == ERROR);
    assign cpu_hold = (state != DONE);

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (accept) begin
            case (state)
                IDLE:  if (byte_data == START_BYTE) state_next = COUNT;
                COUNT: state_next = (byte_data == 8'd0) ? ERROR : DATA;
                DATA: begin
                    if (byte_idx == 2'd3 && last_word) begin
`ifdef LOADER_CHECKSUM_EN
                        state_next = CHECK;
`else
                        state_next = DONE;
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK: state_next = (byte_data == csum) ? DONE : ERROR;
`endif
                DONE, ERROR: if (byte_data == START_BYTE) state_next = COUNT;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_en     <= 1'b0;
            wr_addr   <= BASE;
            wr_data   <= 32'd0;
            count_q   <= 8'd0;
            word_cnt  <= 8'd0;
            byte_idx  <= 2'd0;
            asm_q     <= 24'd0;
            next_addr <= BASE;
`ifdef LOADER_CHECKSUM_EN
            csum      <= 8'd0;
`endif
        end else begin
            wr_en <= 1'b0;
            if (accept) begin
                case (state)
                    COUNT: begin
                        if (byte_data != 8'd0) count_q <= byte_data;
                        word_cnt  <= 8'd0;
                        byte_idx  <= 2'd0;
                        next_addr <= BASE;
`ifdef LOADER_CHECKSUM_EN
                        csum      <= 8'd0;
`endif
                    end
                    DATA: begin
                        asm_q    <= {asm_q[15:0], byte_data};
                        byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum     <= csum + byte_data;
`endif
                        // Fourth byte completes the big-endian word; write lands next cycle
                        if (byte_idx == 2'd3) begin
                            wr_en     <= 1'b1;
                            wr_data   <= {asm_q, byte_data};
                            wr_addr   <= next_addr;
                            next_addr <= next_addr + ADDR_W'(4);
                            word_cnt  <= word_cnt + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader (follows LOADER_CHECKSUM_EN)
module tb_imem_loader;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready, wr_en, cpu_hold, done, err;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        byte_ready2, wr_en2, cpu_hold2, done2, err2;
    logic [3:0]  wr_addr2;
    logic [31:0] wr_data2;

    int n_checks = 0;
    int n_errors = 0;
    int gap_max  = 0;

    logic [7:0]  q_addr[$];
    logic [31:0] q_data[$];
    logic [3:0]  q2_addr[$];
    logic [31:0] fw[4];

    always #5 CLK = ~CLK;

    imem_loader dut (
        .CLK(CLK), .RST(RST), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    imem_loader #(.ADDR_W(4), .BASE_ADDR(8)) dut_wrap (
        .CLK(CLK), .RST(RST), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready2), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .cpu_hold(cpu_hold2), .done(done2), .err(err2)
    );

    always @(negedge CLK) begin
        if (wr_en) begin
            q_addr.push_back(wr_addr);
            q_data.push_back(wr_data);
        end
        if (wr_en2) q2_addr.push_back(wr_addr2);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int gap;
        gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        for (int i = 0; i < gap; i++) begin
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
            tick(1);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        tick(1);
        byte_valid = 1'b0;
    endtask

    task automatic send_payload(input int n);
        for (int k = 0; k < n; k++)
            for (int j = 3; j >= 0; j--)
                send_byte(fw[k][j*8 +: 8]);
    endtask

    task automatic send_csum(input int n, input logic [7:0] delta);
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] s;
        s = 8'd0;
        for (int k = 0; k < n; k++)
            for (int j = 0; j < 4; j++)
                s = s + fw[k][j*8 +: 8];
        send_byte(s + delta);
`else
        if (n < 0 || delta != 8'd0) tick(0);
`endif
    endtask

    task automatic clear_q();
        q_addr.delete();
        q_data.delete();
        q2_addr.delete();
    endtask

    initial begin
        // Reset values
        tick(3);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'h00);
        chk("rst_wr_data", wr_data, 32'h0);
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ready", 32'(byte_ready), 32'd0);
        chk("rst_wrap_addr", 32'(wr_addr2), 32'd8);
        RST = 1'b0;
        #1;
        chk("ready_run", 32'(byte_ready), 32'd1);

        // Single-word frame A5 01 8C 22 00 04 (B2)
        clear_q();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h8C);
        send_byte(8'h22);
        send_byte(8'h00);
        chk("w1_pre_en", 32'(wr_en), 32'd0);
        send_byte(8'h04);
        chk("w1_en", 32'(wr_en), 32'd1);
        chk("w1_addr", 32'(wr_addr), 32'h00);
        chk("w1_data", wr_data, 32'h8C220004);
`ifdef LOADER_CHECKSUM_EN
        chk("w1_done_wait", 32'(done), 32'd0);
        send_byte(8'hB2);
`else
        tick(1);
`endif
        chk("w1_en_off", 32'(wr_en), 32'd0);
        chk("w1_done", 32'(done), 32'd1);
        chk("w1_hold", 32'(cpu_hold), 32'd0);
        chk("w1_err", 32'(err), 32'd0);
        chk("w1_nwrites", q_addr.size(), 32'd1);

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum: word written, frame rejected, then recovered
        clear_q();
        send_byte(8'hA5);
        chk("reload_hold", 32'(cpu_hold), 32'd1);
        chk("reload_done", 32'(done), 32'd0);
        fw[0] = 32'h8C220004;
        send_byte(8'h01);
        send_payload(1);
        send_byte(8'hB3);
        chk("bad_err", 32'(err), 32'd1);
        chk("bad_done", 32'(done), 32'd0);
        chk("bad_hold", 32'(cpu_hold), 32'd1);
        chk("bad_nwrites", q_addr.size(), 32'd1);
        if (q_data.size() > 0) chk("bad_word", q_data[0], 32'h8C220004);
        send_byte(8'hA5);
        chk("bad_err_clr", 32'(err), 32'd0);
        send_byte(8'h01);
        send_payload(1);
        send_csum(1, 8'd0);
        chk("recov_done", 32'(done), 32'd1);
        chk("recov_err", 32'(err), 32'd0);
`endif

        // Leading garbage and gapped two-word frame
        clear_q();
        gap_max = 3;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h3C);
        send_byte(8'hA5);
        send_byte(8'h02);
        fw[0] = 32'h11223344;
        fw[1] = 32'h55667788;
        send_payload(2);
        send_csum(2, 8'd0);
        gap_max = 0;
        tick(2);
        chk("gap_nwrites", q_addr.size(), 32'd2);
        if (q_addr.size() == 2) begin
            chk("gap_addr0", 32'(q_addr[0]), 32'h00);
            chk("gap_data0", q_data[0], 32'h11223344);
            chk("gap_addr1", 32'(q_addr[1]), 32'h04);
            chk("gap_data1", q_data[1], 32'h55667788);
        end
        chk("gap_done", 32'(done), 32'd1);

        // Reset after two data bytes of the first word
        clear_q();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'hDE);
        send_byte(8'hAD);
        RST = 1'b1;
        tick(1);
        chk("mid_wr_addr", 32'(wr_addr), 32'h00);
        chk("mid_wr_data", wr_data, 32'h0);
        chk("mid_hold", 32'(cpu_hold), 32'd1);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_ready", 32'(byte_ready), 32'd0);
        RST = 1'b0;
        tick(1);
        chk("mid_nwrites", q_addr.size(), 32'd0);
        send_byte(8'hA5);
        send_byte(8'h01);
        fw[0] = 32'hCAFEF00D;
        send_payload(1);
        send_csum(1, 8'd0);
        tick(1);
        chk("post_nwrites", q_addr.size(), 32'd1);
        if (q_data.size() > 0) chk("post_word", q_data[0], 32'hCAFEF00D);
        chk("post_done", 32'(done), 32'd1);

        // Zero-length frame
        clear_q();
        send_byte(8'hA5);
        send_byte(8'h00);
        chk("n0_err", 32'(err), 32'd1);
        chk("n0_hold", 32'(cpu_hold), 32'd1);
        tick(2);
        chk("n0_nwrites", q_addr.size(), 32'd0);

        // Three words: wraps in the 4-bit instance
        clear_q();
        send_byte(8'hA5);
        chk("n0_err_clr", 32'(err), 32'd0);
        send_byte(8'h03);
        fw[0] = 32'h00000001;
        fw[1] = 32'h00000002;
        fw[2] = 32'h00000003;
        send_payload(3);
        send_csum(3, 8'd0);
        tick(2);
        chk("wrap_nwrites", q2_addr.size(), 32'd3);
        if (q2_addr.size() == 3) begin
            chk("wrap_addr0", 32'(q2_addr[0]), 32'd8);
            chk("wrap_addr1", 32'(q2_addr[1]), 32'd12);
            chk("wrap_addr2", 32'(q2_addr[2]), 32'd0);
        end
        if (q_addr.size() == 3) chk("nowrap_addr2", 32'(q_addr[2]), 32'd8);
        else chk("nowrap_nwrites", q_addr.size(), 32'd3);
        chk("wrap_done", 32'(done2), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
